// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch front end.
// Redirect kinds, fetch FSM states and the sequential PC step.
package fetch_pkg;

   localparam logic [1:0] KIND_BRANCH = 2'b00;
   localparam logic [1:0] KIND_JUMP   = 2'b01;
   localparam logic [1:0] KIND_JR     = 2'b10;

   typedef enum logic [1:0] {
      FETCH = 2'b00,
      WAIT  = 2'b01,
      FULL  = 2'b10,
      DRAIN = 2'b11
   } state_e;

   localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Memory, redirect and decode-side bundle of the fetch unit.
// master is the fetch unit; slave is memory/execute/decode.
interface pc_fetch_unit_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
);

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_data;

   logic               redirect_valid;
   logic [1:0]         redirect_kind;
   logic [ADDR_W-1:0]  redirect_base;
   logic [15:0]        redirect_imm;
   logic [25:0]        redirect_target26;
   logic [ADDR_W-1:0]  redirect_reg;

   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr_data;
   logic [ADDR_W-1:0]  instr_pc;
   logic [ADDR_W-1:0]  instr_pc4;
   logic               err_misaligned;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_data,
      input  redirect_valid, redirect_kind, redirect_base,
      input  redirect_imm, redirect_target26, redirect_reg,
      output instr_valid, instr_data, instr_pc, instr_pc4,
      input  instr_ready,
      output err_misaligned
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_data,
      output redirect_valid, redirect_kind, redirect_base,
      output redirect_imm, redirect_target26, redirect_reg,
      input  instr_valid, instr_data, instr_pc, instr_pc4,
      output instr_ready,
      input  err_misaligned
   );

endinterface

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Redirect target computation for branch, jump and jr.
// Reserved kind yields take_o=0 so the redirect is ignored.
module next_pc_calc
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [1:0]        kind_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [15:0]       imm_i,
   input  logic [25:0]       target26_i,
   input  logic [ADDR_W-1:0] reg_i,
   output logic [ADDR_W-1:0] target_o,
   output logic              take_o,
   output logic              misalign_o
);

   logic [ADDR_W-1:0] br;
   logic [ADDR_W-1:0] jmp;
   logic [ADDR_W-1:0] jr;

   assign br = base_i + {{(ADDR_W-18){imm_i[15]}}, imm_i, 2'b00};
   assign jr = {reg_i[ADDR_W-1:2], 2'b00};

   // Jump keeps the region bits above the 28-bit pseudo-direct field
   generate
      if (ADDR_W > 28) begin : g_region
         assign jmp = {base_i[ADDR_W-1:28], target26_i, 2'b00};
      end else begin : g_flat
         assign jmp = {target26_i, 2'b00};
      end
   endgenerate

   always_comb begin
      target_o   = '0;
      take_o     = 1'b0;
      misalign_o = 1'b0;
      unique case (1'b1)
         (kind_i == KIND_BRANCH): begin
            target_o = {br[ADDR_W-1:2], 2'b00};
            take_o   = 1'b1;
         end
         (kind_i == KIND_JUMP): begin
            target_o = jmp;
            take_o   = 1'b1;
         end
         (kind_i == KIND_JR): begin
            target_o   = jr;
            take_o     = 1'b1;
            misalign_o = |reg_i[1:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, single outstanding
// memory request, valid/ready output register, redirect handling.
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic             clk,
   input logic             reset,
   pc_fetch_unit_if.master bus
);

   state_e             state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic               valid_q;
   logic [INSTR_W-1:0] data_q;
   logic [ADDR_W-1:0]  ipc_q;
   logic [ADDR_W-1:0]  ipc4_q;
   logic               err_q;

   logic [ADDR_W-1:0]  tgt;
   logic               take_k;
   logic               mis;
   logic               redir;
   logic               ack;
   logic [ADDR_W-1:0]  pc_plus;

   next_pc_calc #(
      .ADDR_W (ADDR_W)
   ) u_npc (
      .kind_i     (bus.redirect_kind),
      .base_i     (bus.redirect_base),
      .imm_i      (bus.redirect_imm),
      .target26_i (bus.redirect_target26),
      .reg_i      (bus.redirect_reg),
      .target_o   (tgt),
      .take_o     (take_k),
      .misalign_o (mis)
   );

   assign redir   = bus.redirect_valid & take_k;
   assign ack     = bus.imem_ack;
   assign pc_plus = pc_q + ADDR_W'(PC_STEP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         data_q  <= '0;
         ipc_q   <= '0;
         ipc4_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= redir & mis;
         if (redir) begin
            pc_q    <= tgt;
            valid_q <= 1'b0;
            // An un-acked request becomes stale and must be drained
            unique case (state_q)
               FETCH:   state_q <= DRAIN;
               WAIT:    state_q <= ack ? FETCH : DRAIN;
               FULL:    state_q <= FETCH;
               DRAIN:   state_q <= ack ? FETCH : DRAIN;
               default: state_q <= FETCH;
            endcase
         end else begin
            unique case (state_q)
               FETCH: state_q <= WAIT;
               WAIT: begin
                  if (ack) begin
                     data_q  <= bus.imem_data;
                     ipc_q   <= pc_q;
                     ipc4_q  <= pc_plus;
                     pc_q    <= pc_plus;
                     valid_q <= 1'b1;
                     state_q <= FULL;
                  end
               end
               FULL: begin
                  if (bus.instr_ready) begin
                     valid_q <= 1'b0;
                     state_q <= FETCH;
                  end
               end
               DRAIN: begin
                  if (ack) state_q <= FETCH;
               end
               default: state_q <= FETCH;
            endcase
         end
      end
   end

   assign bus.imem_req       = (state_q == FETCH) & ~reset;
   assign bus.imem_addr      = pc_q;
   assign bus.instr_valid    = valid_q;
   assign bus.instr_data     = data_q;
   assign bus.instr_pc       = ipc_q;
   assign bus.instr_pc4      = ipc4_q;
   assign bus.err_misaligned = err_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised instruction-fetch front end for the MIPS-subset core. Owns the program counter. Issues single-outstanding requests to a variable-latency instruction memory and presents each fetched word with its PC to decode through a valid/ready handshake. Resolves branch, jump and jump-register redirects, discarding any in-flight stale response. Intended to replace the fixed PC+4 adder / PC mux path when the core moves to multi-cycle and pipelined operation.

Parameters:
ADDR_W, 32, PC and memory address width; must be >= 28.
INSTR_W, 32, instruction word width.
RESET_PC, 0, PC value loaded on reset; must be word-aligned.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request; memory accepts the request in the same cycle it is asserted
imem_addr  out  ADDR_W  fetch address, equal to the current PC
imem_ack  in  1  one-cycle pulse: response valid
imem_data  in  INSTR_W  response word, valid with imem_ack
redirect_valid  in  1  one-cycle redirect request from execute
redirect_kind  in  2  00 branch, 01 jump, 10 jr, 11 reserved (treated as no redirect)
redirect_base  in  ADDR_W  PC+4 of the redirecting instruction
redirect_imm  in  16  branch offset, in words
redirect_target26  in  26  jump target field
redirect_reg  in  ADDR_W  jr register value
instr_valid  out  1  fetched instruction available
instr_ready  in  1  decode accepts the instruction
instr_data  out  INSTR_W  fetched word
instr_pc  out  ADDR_W  PC of instr_data
instr_pc4  out  ADDR_W  instr_pc+4, with wrap-around modulo 2^ADDR_W
err_misaligned  out  1  one-cycle pulse when a jr target has nonzero bits [1:0]

Behaviour:
- Reset:
  - pc=RESET_PC, state=FETCH.
  - Registered outputs clear: instr_valid=0, instr_data=0, instr_pc=0, instr_pc4=0, err_misaligned=0.
  - imem_req=0 while reset is high.
  - Reset overrides every simultaneous event.
- States:
  - FETCH: imem_req=1, imem_addr=pc. Next state is WAIT.
  - WAIT: one request outstanding, imem_req=0. On imem_ack, capture imem_data, pc and pc+4 into the output register; set instr_valid=1; pc<=pc+4; go to FULL.
  - FULL: instr_valid=1, outputs held stable, imem_req=0. When instr_valid and instr_ready are both high, instr_valid<=0 and the next state is FETCH.
  - DRAIN: one stale request outstanding. On imem_ack, discard the data and go to FETCH.
- Latency and throughput:
  - With memory ack one cycle after the request: request at T, instr_valid at T+2.
  - Minimum of 3 cycles per instruction with instr_ready held high.
- Redirect target (target[1:0] forced to 00):
  - Branch: redirect_base + (sign_extend(redirect_imm) << 2), modulo 2^ADDR_W.
  - Jump: {redirect_base[ADDR_W-1:28], redirect_target26, 2'b00}.
  - jr: redirect_reg with bits [1:0] cleared. err_misaligned=1 the next cycle if redirect_reg[1:0]!=0.
- Redirect priority and effect (redirect_valid with kind!=11 beats all non-reset events):
  - pc<=target and instr_valid<=0.
  - From FETCH: go to DRAIN, because the request was issued this cycle.
  - From WAIT without ack: go to DRAIN.
  - From WAIT with ack in the same cycle: discard the response and go to FETCH.
  - From FULL: go to FETCH. A same-cycle instr_ready still counts as a completed handshake.
  - From DRAIN without ack: pc updates, stay in DRAIN.
  - From DRAIN with ack in the same cycle: pc updates, go to FETCH.
- imem_ack arriving in FETCH or FULL is ignored. This covers a stale ack after a mid-request reset.
- pc+4 wraps from 2^ADDR_W-4 to 0 with no error.

Decomposition:
- Shared package fetch_pkg:
  - redirect kind encodings (KIND_BRANCH=2'b00, KIND_JUMP=2'b01, KIND_JR=2'b10);
  - state encoding (FETCH, WAIT, FULL, DRAIN);
  - constant PC_STEP=4.
- Sub-module next_pc_calc: combinational target computation and misalignment detection, instantiated once.

Test Plan:
- Reset then release: the next cycle gives imem_req=1, imem_addr=0x0. Ack 0x20080005 one cycle later gives instr_valid=1, instr_data=0x20080005, instr_pc=0, instr_pc4=4. After instr_ready, the next request goes to 0x4.
- Backpressure: hold instr_ready=0 for 10 cycles with an instruction in FULL. Outputs stay constant, imem_req stays 0. Release gives exactly one handshake, then a request to pc+4.
- Branch targets from base 0x10: imm 0xFFFC fetches 0x0, imm 0x0003 fetches 0x1C. Jump with base 0xA0000004 and target26 0x0000100 fetches 0xA0000400.
- Redirect in WAIT to 0x40 with a stale ack 2 cycles later: the stale word never appears on instr_valid, and the next imem_addr is 0x40. Redirect coincident with ack: no DRAIN, and the next cycle requests 0x40.
- jr to 0x103: err_misaligned pulses one cycle and the fetch goes to 0x100. Reset asserted in WAIT followed by a late ack: the ack is ignored, and the fetch restarts at RESET_PC.
- Wrap-around with ADDR_W=32: instruction at 0xFFFFFFFC gives instr_pc4=0x0, and the next fetch is 0x0.
